// File: rtl/wb_burst_mem_slave_if.sv
// WISHBONE B3 bus bundle between the DMA master and the burst memory slave.
interface wb_burst_mem_slave_if #(
  parameter int DW = 32,
  parameter int AW = 32
) ();
  logic [AW-1:0]   m_wb_adr_o;
  logic [DW/8-1:0] m_wb_sel_o;
  logic            m_wb_we_o;
  logic [DW-1:0]   m_wb_dat_o;
  logic            m_wb_cyc_o;
  logic            m_wb_stb_o;
  logic [2:0]      m_wb_cti_o;
  logic [1:0]      m_wb_bte_o;
  logic [DW-1:0]   m_wb_dat_i;
  logic            m_wb_ack_i;
  logic            m_wb_err_i;

  modport master (
    output m_wb_adr_o, m_wb_sel_o, m_wb_we_o, m_wb_dat_o,
           m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
    input  m_wb_dat_i, m_wb_ack_i, m_wb_err_i
  );

  modport slave (
    input  m_wb_adr_o, m_wb_sel_o, m_wb_we_o, m_wb_dat_o,
           m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
    output m_wb_dat_i, m_wb_ack_i, m_wb_err_i
  );
endinterface

// File: rtl/wb_burst_mem_slave.sv
// WISHBONE B3 slave memory with wait states, byte lanes and an error window.
// Define WB_MEM_BURST_EN to build CTI/BTE registered-feedback burst support.
module wb_burst_mem_slave #(
  parameter int          DW          = 32,
  parameter int          AW          = 32,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [AW-1:0] ERR_BASE  = AW'(32'hFFFF_F000),
  parameter logic [AW-1:0] ERR_MASK  = AW'(32'hFFFF_F000)
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  wb_burst_mem_slave_if.slave  wb,
  output logic [15:0]          beat_cnt
);

  localparam int SH  = $clog2(DW / 8);
  localparam int IW  = AW - SH;
  localparam int DAW = $clog2(DEPTH);

`ifdef WB_MEM_BURST_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_BURST} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;
`endif

  state_e          state_q, state_d;
  logic [3:0]      waitCnt_q, waitCnt_d;
  logic [IW-1:0]   wordIdx_q, wordIdx_d;
  logic            errBeat_q, errBeat_d;
  logic [15:0]     beatCnt_q;
  logic            ackNow, errNow, wrEn;
  logic [IW-1:0]   reqIdx;
  logic [DW-1:0]   mem [DEPTH];

  function automatic logic isErr(input logic [AW-1:0] adr, input logic [IW-1:0] idx);
    isErr = ((adr & ERR_MASK) == (ERR_BASE & ERR_MASK)) || (idx >= IW'(DEPTH));
  endfunction

`ifdef WB_MEM_BURST_EN
  logic [1:0] bte_q, bte_d;
  logic       predErr;

  // Wrap bursts keep the upper index bits and roll the low log2(N) bits.
  function automatic logic [IW-1:0] nextIdx(input logic [IW-1:0] idx, input logic [1:0] bte);
    logic [IW-1:0] inc;
    logic [IW-1:0] m;
    inc = idx + 1'b1;
    case (bte)
      2'b01:   m = IW'(3);
      2'b10:   m = IW'(7);
      2'b11:   m = IW'(15);
      default: m = '0;
    endcase
    nextIdx = (bte == 2'b00) ? inc : ((idx & ~m) | (inc & m));
  endfunction

  assign predErr = isErr({wordIdx_q, {SH{1'b0}}}, wordIdx_q);
`endif

  assign reqIdx = wb.m_wb_adr_o[AW-1:SH];

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    wordIdx_d = wordIdx_q;
    errBeat_d = errBeat_q;
    ackNow    = 1'b0;
    errNow    = 1'b0;
    wrEn      = 1'b0;
`ifdef WB_MEM_BURST_EN
    bte_d     = bte_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (wb.m_wb_cyc_o && wb.m_wb_stb_o) begin
          waitCnt_d = 4'(WAIT_STATES);
          wordIdx_d = reqIdx;
          errBeat_d = isErr(wb.m_wb_adr_o, reqIdx);
`ifdef WB_MEM_BURST_EN
          bte_d     = wb.m_wb_bte_o;
`endif
          state_d   = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        waitCnt_d = waitCnt_q - 1'b1;
        if (waitCnt_q <= 4'd1) begin
          waitCnt_d = '0;
          state_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        ackNow  = !errBeat_q;
        errNow  = errBeat_q;
        wrEn    = wb.m_wb_we_o && !errBeat_q;
        state_d = ST_IDLE;
`ifdef WB_MEM_BURST_EN
        if (wb.m_wb_cti_o == 3'b010 && !errBeat_q) begin
          state_d   = ST_BURST;
          wordIdx_d = nextIdx(wordIdx_q, bte_q);
        end
`endif
      end
`ifdef WB_MEM_BURST_EN
      // Address bus is ignored here; the predicted index drives every beat.
      ST_BURST: begin
        if (wb.m_wb_stb_o) begin
          ackNow = !predErr;
          errNow = predErr;
          wrEn   = wb.m_wb_we_o && !predErr;
          if (predErr || wb.m_wb_cti_o == 3'b111 || wb.m_wb_cti_o == 3'b000) begin
            state_d = ST_IDLE;
          end else begin
            wordIdx_d = nextIdx(wordIdx_q, bte_q);
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (!wb.m_wb_cyc_o) begin
      state_d = ST_IDLE;
      ackNow  = 1'b0;
      errNow  = 1'b0;
      wrEn    = 1'b0;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q   <= ST_IDLE;
      waitCnt_q <= '0;
      wordIdx_q <= '0;
      errBeat_q <= 1'b0;
      beatCnt_q <= '0;
`ifdef WB_MEM_BURST_EN
      bte_q     <= 2'b00;
`endif
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      wordIdx_q <= wordIdx_d;
      errBeat_q <= errBeat_d;
      if (ackNow) beatCnt_q <= beatCnt_q + 16'd1;
`ifdef WB_MEM_BURST_EN
      bte_q     <= bte_d;
`endif
    end
  end

  // Storage is deliberately unreset; a write only exists while the FSM is out of reset.
  always_ff @(posedge wb_clk) begin
    if (wrEn) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (wb.m_wb_sel_o[b]) mem[wordIdx_q[DAW-1:0]][b*8 +: 8] <= wb.m_wb_dat_o[b*8 +: 8];
      end
    end
  end

  assign wb.m_wb_dat_i = ackNow ? mem[wordIdx_q[DAW-1:0]] : '0;
  assign wb.m_wb_ack_i = ackNow;
  assign wb.m_wb_err_i = errNow;
  assign beat_cnt      = beatCnt_q;

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// Scoreboard bench for wb_burst_mem_slave: stimulus pushes expected beats,
// a negedge monitor pops and compares them whenever ack or err is seen.
module tb_wb_burst_mem_slave;

  localparam int WS  = 3;
  localparam int LAT = WS + 1;

  typedef struct packed {
    logic        isErr;
    logic        chkData;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic [15:0] beatCnt;
  exp_t        expQ[$];
  int          numChecks = 0;
  int          numFailures = 0;
  int          expBeats = 0;

  wb_burst_mem_slave_if #(.DW(32), .AW(32)) bus ();

  wb_burst_mem_slave #(
    .DW(32), .AW(32), .DEPTH(1024), .WAIT_STATES(WS),
    .ERR_BASE(32'hFFFF_F000), .ERR_MASK(32'hFFFF_F000)
  ) dut (
    .wb_clk   (clk),
    .wb_rst   (rstN),
    .wb       (bus),
    .beat_cnt (beatCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFailures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input logic isErr, input logic chk, input logic [31:0] d);
    exp_t e;
    e.isErr   = isErr;
    e.chkData = chk;
    e.data    = isErr ? 32'h0 : d;
    expQ.push_back(e);
    if (!isErr) expBeats++;
  endtask

  task automatic idleBus();
    bus.m_wb_cyc_o = 1'b0;
    bus.m_wb_stb_o = 1'b0;
    bus.m_wb_we_o  = 1'b0;
    bus.m_wb_adr_o = 32'h0;
    bus.m_wb_dat_o = 32'h0;
    bus.m_wb_sel_o = 4'h0;
    bus.m_wb_cti_o = 3'b000;
    bus.m_wb_bte_o = 2'b00;
  endtask

  // Counts extra cycles until a termination appears; 0 means ack in the current cycle.
  task automatic waitBeat(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (!(bus.m_wb_ack_i || bus.m_wb_err_i) && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                               input logic [3:0] sel, input logic [2:0] cti, input logic expErr,
                               input logic [31:0] expData, input logic chk, input string name);
    int lat;
    pushExp(expErr, chk, expData);
    @(posedge clk); #1;
    bus.m_wb_adr_o = adr;
    bus.m_wb_we_o  = we;
    bus.m_wb_dat_o = wdat;
    bus.m_wb_sel_o = sel;
    bus.m_wb_cti_o = cti;
    bus.m_wb_bte_o = 2'b01;
    bus.m_wb_cyc_o = 1'b1;
    bus.m_wb_stb_o = 1'b1;
    waitBeat(lat);
    checkOutput({name, "_latency"}, 32'(lat), 32'(LAT));
    @(posedge clk); #1;
    idleBus();
    @(negedge clk);
    checkOutput({name, "_ackWidth"}, {30'b0, bus.m_wb_ack_i, bus.m_wb_err_i}, 32'h0);
  endtask

`ifdef WB_MEM_BURST_EN
  task automatic runBurst(input logic [31:0] adr, input logic [1:0] bte, input int nBeats,
                          input int gapAfter, input string name);
    int lat;
    @(posedge clk); #1;
    bus.m_wb_adr_o = adr;
    bus.m_wb_we_o  = 1'b0;
    bus.m_wb_sel_o = 4'hF;
    bus.m_wb_cti_o = 3'b010;
    bus.m_wb_bte_o = bte;
    bus.m_wb_cyc_o = 1'b1;
    bus.m_wb_stb_o = 1'b1;
    for (int b = 1; b <= nBeats; b++) begin
      waitBeat(lat);
      checkOutput({name, "_beatLatency"}, 32'(lat), (b == 1) ? 32'(LAT) : 32'h0);
      @(posedge clk); #1;
      bus.m_wb_adr_o = 32'h0000_0FF0;
      if (b == nBeats) begin
        @(negedge clk);
        checkOutput({name, "_endAck"}, {30'b0, bus.m_wb_ack_i, bus.m_wb_err_i}, 32'h0);
        @(posedge clk); #1;
        idleBus();
      end else begin
        if (b == nBeats - 1) bus.m_wb_cti_o = 3'b111;
        if (b == gapAfter) begin
          bus.m_wb_stb_o = 1'b0;
          repeat (2) begin
            @(negedge clk);
            checkOutput({name, "_gapAck"}, {30'b0, bus.m_wb_ack_i, bus.m_wb_err_i}, 32'h0);
            @(posedge clk); #1;
          end
          bus.m_wb_stb_o = 1'b1;
        end
      end
    end
  endtask
`endif

  // Scoreboard monitor: independent of the stimulus flow.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.m_wb_ack_i && bus.m_wb_err_i) begin
        numChecks++;
        numFailures++;
        $display("[TB] FAIL ackErrExclusive actual=ack1_err1 expected=one_of at %0t", $time);
      end else if (bus.m_wb_ack_i || bus.m_wb_err_i) begin
        if (expQ.size() == 0) begin
          numChecks++;
          numFailures++;
          $display("[TB] FAIL unexpectedBeat actual=ack%0b_err%0b expected=none at %0t",
                   bus.m_wb_ack_i, bus.m_wb_err_i, $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("beatIsErr", {31'b0, bus.m_wb_err_i}, {31'b0, e.isErr});
          if (e.chkData) checkOutput("beatData", bus.m_wb_dat_i, e.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    idleBus();
    rstN = 1'b0;
    bus.m_wb_adr_o = 32'h0000_000C;
    bus.m_wb_cyc_o = 1'b1;
    bus.m_wb_stb_o = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetAck", {31'b0, bus.m_wb_ack_i}, 32'h0);
    checkOutput("resetErr", {31'b0, bus.m_wb_err_i}, 32'h0);
    checkOutput("resetDat", bus.m_wb_dat_i, 32'h0);
    checkOutput("resetBeatCnt", {16'b0, beatCnt}, 32'h0);
    pushExp(1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rstN = 1'b1;
    waitBeat(lat);
    checkOutput("releaseLatency", 32'(lat), 32'(LAT));
    @(posedge clk); #1;
    idleBus();
    @(negedge clk);
    checkOutput("releaseBeatCnt", {16'b0, beatCnt}, 32'(expBeats));

    for (int i = 0; i < 16; i++)
      applyStimulus(32'(i * 4), 1'b1, 32'(i), 4'hF, 3'b000, 1'b0, 32'h0, 1'b0, "preload");

    applyStimulus(32'h100, 1'b1, 32'h0, 4'hF, 3'b000, 1'b0, 32'h0, 1'b0, "zeroFill");
    applyStimulus(32'h100, 1'b1, 32'hDEAD_BEEF, 4'b0101, 3'b000, 1'b0, 32'h0, 1'b0, "laneWrite");
    applyStimulus(32'h100, 1'b0, 32'h0, 4'hF, 3'b000, 1'b0, 32'h00AD_00EF, 1'b1, "laneRead");
    checkOutput("classicBeatCnt", {16'b0, beatCnt}, 32'(expBeats));

    applyStimulus(32'hFFFF_F010, 1'b1, 32'hBAD0_BAD0, 4'hF, 3'b000, 1'b1, 32'h0, 1'b1, "errWindowWrite");
    applyStimulus(32'h0000_1000, 1'b0, 32'h0, 4'hF, 3'b000, 1'b1, 32'h0, 1'b1, "errDepthRead");
    applyStimulus(32'h0000_0010, 1'b0, 32'h0, 4'hF, 3'b000, 1'b0, 32'h4, 1'b1, "memUnchanged");
    checkOutput("errBeatCnt", {16'b0, beatCnt}, 32'(expBeats));

`ifdef WB_MEM_BURST_EN
    pushExp(1'b0, 1'b1, 32'd6); pushExp(1'b0, 1'b1, 32'd7);
    pushExp(1'b0, 1'b1, 32'd4); pushExp(1'b0, 1'b1, 32'd5);
    runBurst(32'd24, 2'b01, 4, 0, "wrap4");
    checkOutput("wrap4BeatCnt", {16'b0, beatCnt}, 32'(expBeats));

    pushExp(1'b0, 1'b1, 32'd13); pushExp(1'b0, 1'b1, 32'd14);
    pushExp(1'b0, 1'b1, 32'd15); pushExp(1'b0, 1'b1, 32'd8);
    runBurst(32'd52, 2'b10, 4, 0, "wrap8");

    pushExp(1'b0, 1'b1, 32'd8);  pushExp(1'b0, 1'b1, 32'd9);
    pushExp(1'b0, 1'b1, 32'd10); pushExp(1'b0, 1'b1, 32'd11);
    runBurst(32'd32, 2'b00, 4, 2, "linearGap");

    pushExp(1'b0, 1'b0, 32'h0); pushExp(1'b0, 1'b0, 32'h0); pushExp(1'b1, 1'b1, 32'h0);
    runBurst(32'(1022 * 4), 2'b00, 3, 0, "predictedErr");
    checkOutput("burstBeatCnt", {16'b0, beatCnt}, 32'(expBeats));

    pushExp(1'b0, 1'b1, 32'd0); pushExp(1'b0, 1'b1, 32'd1);
    @(posedge clk); #1;
    bus.m_wb_adr_o = 32'h0;
    bus.m_wb_sel_o = 4'hF;
    bus.m_wb_cti_o = 3'b010;
    bus.m_wb_cyc_o = 1'b1;
    bus.m_wb_stb_o = 1'b1;
    waitBeat(lat);
    checkOutput("midBurstFirstLatency", 32'(lat), 32'(LAT));
    @(posedge clk); #1;
    waitBeat(lat);
    checkOutput("midBurstSecondLatency", 32'(lat), 32'h0);
    @(posedge clk); #2;
    rstN = 1'b0;
    #1;
    checkOutput("midBurstResetAck", {30'b0, bus.m_wb_ack_i, bus.m_wb_err_i}, 32'h0);
    checkOutput("midBurstResetDat", bus.m_wb_dat_i, 32'h0);
    checkOutput("midBurstResetBeatCnt", {16'b0, beatCnt}, 32'h0);
    idleBus();
    expBeats = 0;
    @(posedge clk); #1;
    rstN = 1'b1;
    applyStimulus(32'h14, 1'b0, 32'h0, 4'hF, 3'b000, 1'b0, 32'd5, 1'b1, "afterBurstReset");
    checkOutput("afterBurstResetBeatCnt", {16'b0, beatCnt}, 32'(expBeats));
`else
    applyStimulus(32'd24, 1'b0, 32'h0, 4'hF, 3'b010, 1'b0, 32'd6, 1'b1, "classicCti6");
    applyStimulus(32'd28, 1'b0, 32'h0, 4'hF, 3'b010, 1'b0, 32'd7, 1'b1, "classicCti7");
    applyStimulus(32'd16, 1'b0, 32'h0, 4'hF, 3'b010, 1'b0, 32'd4, 1'b1, "classicCti4");
    applyStimulus(32'd20, 1'b0, 32'h0, 4'hF, 3'b111, 1'b0, 32'd5, 1'b1, "classicCti5");
    checkOutput("classicCtiBeatCnt", {16'b0, beatCnt}, 32'(expBeats));
`endif

    @(posedge clk); #1;
    bus.m_wb_adr_o = 32'd36;
    bus.m_wb_we_o  = 1'b1;
    bus.m_wb_dat_o = 32'hAAAA_AAAA;
    bus.m_wb_sel_o = 4'hF;
    bus.m_wb_cyc_o = 1'b1;
    bus.m_wb_stb_o = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("midWriteResetAck", {30'b0, bus.m_wb_ack_i, bus.m_wb_err_i}, 32'h0);
    idleBus();
    expBeats = 0;
    @(posedge clk); #1;
    rstN = 1'b1;
    applyStimulus(32'd36, 1'b0, 32'h0, 4'hF, 3'b000, 1'b0, 32'd9, 1'b1, "writeDiscarded");
    checkOutput("finalBeatCnt", {16'b0, beatCnt}, 32'(expBeats));

    repeat (4) @(negedge clk);
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFailures);
    $finish;
  end

endmodule
